// File: rtl/fpga_spi_pkg.sv
// Shared definitions for the FPGA SPI link: word size, synchroniser depth,
// mode-0 clocking constants and the slave state encoding.
package fpga_spi_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int SYNC_STAGES_DEF = 2;

   // Word returned to the master when nothing has been queued for transmit
   localparam logic [DATA_WIDTH_DEF-1:0] IDLE_WORD_DEF = '1;

   // SPI mode 0: SCLK idles low, data sampled on the rising edge
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, followed by a one-cycle
// rise/fall event detector on the synchronised level.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rst_val_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              level;

   assign level = sync_q[STAGES-1];

   // Shift the pin through the synchroniser chain and remember the last level
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {STAGES{rst_val_i}};
         prev_q <= rst_val_i;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= level;
      end
   end

   assign rise_o = level & ~prev_q;
   assign fall_o = ~level & prev_q;

endmodule

// File: rtl/fpga_spi_slave.sv
// SPI mode-0 slave, fully oversampled by the system clock. MSB-first words in
// on MOSI and out on MISO, with a one-deep transmit buffer ahead of the shifter.
module fpga_spi_slave
   import fpga_spi_pkg::*;
#(
   parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int                    SYNC_STAGES = SYNC_STAGES_DEF,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = {DATA_WIDTH{1'b1}}
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  sclk_i,
   input  logic                  ss_i,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic                  miso_oe_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_load_i,
   output logic                  tx_empty_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   output logic                  busy_o,
   output logic                  tx_underrun_o,
   output logic                  frame_err_o
);

   localparam int              CNT_W    = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

   logic sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   mosi_s;

   spi_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
   logic                  tx_empty_q, tx_empty_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  reload_q, reload_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  underrun_q, underrun_d;
   logic                  frame_err_q, frame_err_d;
   logic                  do_load;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .rst_val_i (CPOL),
      .d_i       (sclk_i),
      .rise_o    (sclk_rise),
      .fall_o    (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .rst_val_i (1'b1),
      .d_i       (ss_i),
      .rise_o    (ss_rise),
      .fall_o    (ss_fall)
   );

   // MOSI only needs its level; same depth as SCLK so the sample lines up
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mosi_sync_q <= '1;
      end else begin
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      end
   end

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Frame sequencing, shifting, word loads and the TX buffer write port
   always_comb begin
      state_d     = state_q;
      tx_buf_d    = tx_buf_q;
      tx_empty_d  = tx_empty_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      cnt_d       = cnt_q;
      reload_d    = reload_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      frame_err_d = 1'b0;
      do_load     = 1'b0;

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               do_load = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d  = IDLE;
               cnt_d    = '0;
               reload_d = 1'b0;
               if (cnt_q != '0) begin
                  frame_err_d = 1'b1;
               end
            end else begin
               if (cnt_q == CNT_FULL) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
                  cnt_d      = '0;
                  reload_d   = 1'b1;
               end
               if (sclk_rise) begin
                  rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                  cnt_d      = cnt_q + CNT_W'(1);
               end else if (sclk_fall) begin
                  if (reload_q) begin
                     do_load  = 1'b1;
                     reload_d = 1'b0;
                  end else begin
                     tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b1};
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_load) begin
         cnt_d = '0;
         if (!tx_empty_q) begin
            tx_shift_d = tx_buf_q;
            tx_empty_d = 1'b1;
         end else begin
            tx_shift_d = IDLE_WORD;
            underrun_d = 1'b1;
         end
      end

      if (tx_load_i) begin
         tx_buf_d   = tx_data_i;
         tx_empty_d = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         tx_buf_q    <= '0;
         tx_empty_q  <= 1'b1;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         cnt_q       <= '0;
         reload_q    <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_buf_q    <= tx_buf_d;
         tx_empty_q  <= tx_empty_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         cnt_q       <= cnt_d;
         reload_q    <= reload_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign miso_oe_o     = (state_q == ACTIVE);
   assign busy_o        = (state_q == ACTIVE);
   assign miso_o        = (state_q == ACTIVE) ? tx_shift_q[DATA_WIDTH-1] : 1'b1;
   assign tx_empty_o    = tx_empty_q;
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign tx_underrun_o = underrun_q;
   assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_fpga_spi_slave.sv
// Bench for fpga_spi_slave: a mode-0 master model drives frames at 1 MHz SCLK
// against a 50 MHz system clock; a transaction-level model predicts MISO words,
// received words and pulse counts.
module tb_fpga_spi_slave;

   localparam int HALF = 25;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       ss = 1'b1;
   logic       mosi = 1'b1;
   logic [7:0] txData = 8'h00;
   logic       txLoad = 1'b0;
   logic       miso, misoOe, txEmpty, rxValid, busy, txUnderrun, frameErr;
   logic [7:0] rxData;

   fpga_spi_slave dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .sclk_i        (sclk),
      .ss_i          (ss),
      .mosi_i        (mosi),
      .miso_o        (miso),
      .miso_oe_o     (misoOe),
      .tx_data_i     (txData),
      .tx_load_i     (txLoad),
      .tx_empty_o    (txEmpty),
      .rx_data_o     (rxData),
      .rx_valid_o    (rxValid),
      .busy_o        (busy),
      .tx_underrun_o (txUnderrun),
      .frame_err_o   (frameErr)
   );

   always #10 clk = ~clk;

   int vecCount = 0;
   int missCount = 0;

   int rxValidCnt = 0;
   int underrunCnt = 0;
   int frameErrCnt = 0;
   logic [7:0] rxSeen[$];

   bit         modelFull = 1'b0;
   logic [7:0] modelBuf = 8'h00;
   logic [7:0] modelRx = 8'h00;
   int         expRxValid = 0;
   int         expUnderrun = 0;
   int         expFrameErr = 0;

   logic [7:0] mosiW[4];
   bit         midLoad[4];
   logic [7:0] midVal[4];
   logic [7:0] expW[4];
   logic [7:0] gotW[4];

   // Count output pulses and capture received words away from the clock edge
   always @(negedge clk) begin
      if (rxValid) begin
         rxValidCnt++;
         rxSeen.push_back(rxData);
      end
      if (txUnderrun) underrunCnt++;
      if (frameErr) frameErrCnt++;
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: a word load takes the buffered word if present, else all ones
   function automatic logic [7:0] modelTake();
      logic [7:0] w;
      if (modelFull) begin
         w = modelBuf;
      end else begin
         w = 8'hFF;
         expUnderrun++;
      end
      modelFull = 1'b0;
      return w;
   endfunction

   task automatic loadTx(input logic [7:0] v);
      txData = v;
      txLoad = 1'b1;
      waitClk(1);
      txLoad = 1'b0;
      modelFull = 1'b1;
      modelBuf = v;
   endtask

   task automatic checkCounts(input string tag);
      vecCount++;
      if (rxValidCnt !== expRxValid) begin
         missCount++;
         $display("[TB] FAIL %s rx_valid count: got %0d want %0d", tag, rxValidCnt, expRxValid);
      end
      vecCount++;
      if (underrunCnt !== expUnderrun) begin
         missCount++;
         $display("[TB] FAIL %s underrun count: got %0d want %0d", tag, underrunCnt, expUnderrun);
      end
      vecCount++;
      if (frameErrCnt !== expFrameErr) begin
         missCount++;
         $display("[TB] FAIL %s frame_err count: got %0d want %0d", tag, frameErrCnt, expFrameErr);
      end
   endtask

   // One SS frame of n words; optional TX_LOAD collision with the opening load
   task automatic runFrame(input string tag, input int n, input bit collide, input logic [7:0] collideVal);
      bit last;
      waitClk(1);
      ss = 1'b0;
      expW[0] = modelTake();
      if (collide) begin
         waitClk(2);
         txData = collideVal;
         txLoad = 1'b1;
         waitClk(1);
         txLoad = 1'b0;
         modelFull = 1'b1;
         modelBuf = collideVal;
         waitClk(HALF - 3);
      end else begin
         waitClk(HALF);
      end
      vecCount++;
      if (txEmpty !== !modelFull) begin
         missCount++;
         $display("[TB] FAIL %s tx_empty after SS fall: got %b want %b", tag, txEmpty, !modelFull);
      end
      for (int w = 0; w < n; w++) begin
         for (int b = 7; b >= 0; b--) begin
            last = (w == n - 1) && (b == 0);
            mosi = mosiW[w][b];
            waitClk(HALF);
            gotW[w][b] = miso;
            sclk = 1'b1;
            if (b == 0 && w < n - 1) begin
               waitClk(10);
               if (midLoad[w + 1]) loadTx(midVal[w + 1]);
               else waitClk(1);
               waitClk(HALF - 11);
               expW[w + 1] = modelTake();
            end else begin
               waitClk(HALF);
            end
            sclk = 1'b0;
            if (last) ss = 1'b1;
         end
         expRxValid++;
      end
      waitClk(10);
      for (int w = 0; w < n; w++) begin
         vecCount++;
         if (gotW[w] !== expW[w]) begin
            missCount++;
            $display("[TB] FAIL %s miso word %0d: got %h want %h", tag, w, gotW[w], expW[w]);
         end
         vecCount++;
         if (rxSeen.size() == 0) begin
            missCount++;
            $display("[TB] FAIL %s rx word %0d: got none want %h", tag, w, mosiW[w]);
         end else if (rxSeen[0] !== mosiW[w]) begin
            missCount++;
            $display("[TB] FAIL %s rx word %0d: got %h want %h", tag, w, rxSeen[0], mosiW[w]);
            void'(rxSeen.pop_front());
         end else begin
            void'(rxSeen.pop_front());
         end
      end
      modelRx = mosiW[n - 1];
      vecCount++;
      if (rxData !== modelRx) begin
         missCount++;
         $display("[TB] FAIL %s rx_data hold: got %h want %h", tag, rxData, modelRx);
      end
      vecCount++;
      if ({busy, misoOe, miso, txEmpty} !== {1'b0, 1'b0, 1'b1, !modelFull}) begin
         missCount++;
         $display("[TB] FAIL %s idle outputs busy/oe/miso/empty: got %b want %b", tag,
                  {busy, misoOe, miso, txEmpty}, {1'b0, 1'b0, 1'b1, !modelFull});
      end
      checkCounts(tag);
   endtask

   task automatic clearPlan();
      for (int i = 0; i < 4; i++) begin
         midLoad[i] = 1'b0;
         midVal[i] = 8'h00;
         mosiW[i] = 8'h00;
      end
   endtask

   task automatic test_reset();
      waitClk(3);
      vecCount++;
      if ({miso, misoOe, txEmpty, rxValid, busy, txUnderrun, frameErr} !== 7'b1010000) begin
         missCount++;
         $display("[TB] FAIL reset flags: got %b want %b",
                  {miso, misoOe, txEmpty, rxValid, busy, txUnderrun, frameErr}, 7'b1010000);
      end
      vecCount++;
      if (rxData !== 8'h00) begin
         missCount++;
         $display("[TB] FAIL reset rx_data: got %h want 00", rxData);
      end
      rst_n = 1'b1;
      waitClk(5);
   endtask

   task automatic test_single_word();
      clearPlan();
      loadTx(8'hA5);
      vecCount++;
      if (txEmpty !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL single tx_empty after load: got %b want 0", txEmpty);
      end
      mosiW[0] = 8'h3C;
      runFrame("single", 1, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      clearPlan();
      loadTx(8'h11);
      mosiW[0] = 8'h01;
      mosiW[1] = 8'h02;
      midLoad[1] = 1'b1;
      midVal[1] = 8'h22;
      runFrame("back_to_back", 2, 1'b0, 8'h00);
   endtask

   task automatic test_underrun();
      clearPlan();
      // SCLK activity while deselected must be ignored
      for (int i = 0; i < 4; i++) begin
         sclk = 1'b1;
         waitClk(8);
         sclk = 1'b0;
         waitClk(8);
      end
      mosiW[0] = 8'h55;
      runFrame("underrun", 1, 1'b0, 8'h00);
   endtask

   task automatic test_abort();
      waitClk(1);
      ss = 1'b0;
      void'(modelTake());
      waitClk(HALF);
      for (int b = 0; b < 5; b++) begin
         mosi = b[0];
         waitClk(HALF);
         sclk = 1'b1;
         waitClk(HALF);
         sclk = 1'b0;
      end
      waitClk(HALF);
      ss = 1'b1;
      expFrameErr++;
      waitClk(10);
      vecCount++;
      if (rxData !== modelRx) begin
         missCount++;
         $display("[TB] FAIL abort rx_data: got %h want %h", rxData, modelRx);
      end
      vecCount++;
      if ({busy, misoOe} !== 2'b00) begin
         missCount++;
         $display("[TB] FAIL abort busy/oe: got %b want 00", {busy, misoOe});
      end
      checkCounts("abort");
      clearPlan();
      loadTx(8'hC3);
      mosiW[0] = 8'h9A;
      runFrame("after_abort", 1, 1'b0, 8'h00);
   endtask

   task automatic test_collision();
      clearPlan();
      loadTx(8'h66);
      mosiW[0] = 8'hE1;
      runFrame("collision", 1, 1'b1, 8'h77);
      clearPlan();
      mosiW[0] = 8'h2B;
      runFrame("collision_next", 1, 1'b0, 8'h00);
   endtask

   task automatic test_random();
      int n;
      for (int f = 0; f < 6; f++) begin
         clearPlan();
         n = $urandom_range(1, 3);
         for (int w = 0; w < n; w++) begin
            mosiW[w] = 8'($urandom);
            midLoad[w] = 1'($urandom);
            midVal[w] = 8'($urandom);
         end
         if (midLoad[0]) loadTx(midVal[0]);
         runFrame("random", n, 1'($urandom_range(0, 3) == 0), 8'($urandom));
      end
   endtask

   task automatic test_reset_midframe();
      int rxBefore;
      rxBefore = rxValidCnt;
      waitClk(1);
      ss = 1'b0;
      waitClk(HALF);
      for (int b = 0; b < 4; b++) begin
         mosi = 1'b1;
         waitClk(HALF);
         sclk = 1'b1;
         waitClk(HALF);
         sclk = 1'b0;
      end
      waitClk(HALF);
      sclk = 1'b1;
      waitClk(5);
      #5 rst_n = 1'b0;
      #1;
      vecCount++;
      if ({misoOe, busy} !== 2'b00) begin
         missCount++;
         $display("[TB] FAIL reset_midframe oe/busy: got %b want 00", {misoOe, busy});
      end
      sclk = 1'b0;
      ss = 1'b1;
      waitClk(3);
      rst_n = 1'b1;
      waitClk(10);
      vecCount++;
      if (rxValidCnt !== rxBefore) begin
         missCount++;
         $display("[TB] FAIL reset_midframe rx_valid count: got %0d want %0d", rxValidCnt, rxBefore);
      end
      vecCount++;
      if ({txEmpty, rxData} !== {1'b1, 8'h00}) begin
         missCount++;
         $display("[TB] FAIL reset_midframe empty/rx_data: got %b/%h want 1/00", txEmpty, rxData);
      end
   endtask

   initial begin
      $display("[TB] fpga_spi_slave bench start");
      test_reset();
      test_single_word();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_collision();
      test_random();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
